// File: rtl/vga_timing_arb.sv
// vga_timing_arb: parametrised VGA timing generator with a character-fetch
// address generator and a single-port video-RAM arbiter for CPU accesses.
// Every register updates on the rising edge of the pixel clock.
module vga_timing_arb #(
  parameter int unsigned H_ACTIVE  = 640,
  parameter int unsigned H_FRONT   = 16,
  parameter int unsigned H_SYNC    = 96,
  parameter int unsigned H_BACK    = 48,
  parameter int unsigned V_ACTIVE  = 480,
  parameter int unsigned V_FRONT   = 10,
  parameter int unsigned V_SYNC    = 2,
  parameter int unsigned V_BACK    = 33,
  parameter bit          HSYNC_POL = 1'b0,
  parameter bit          VSYNC_POL = 1'b0,
  parameter int unsigned CHAR_W    = 8,
  parameter int unsigned CHAR_H    = 16,
  parameter int unsigned COLS      = 80,
  parameter int unsigned ADDR_W    = 12,
  parameter int unsigned ACC_MODE  = 0
) (
  input  logic              clk,
  input  logic              rst,
  output logic [10:0]       hx,
  output logic [9:0]        vy,
  output logic              hsync,
  output logic              vsync,
  output logic              pixel_ena,
  output logic              frame_start,
  output logic              fetch_stb,
  output logic [ADDR_W-1:0] fetch_addr,
  output logic              a_sel,
  output logic              ram_we_text,
  output logic              ram_we_color,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic              cpu_sel_color,
  output logic              cpu_rdy
);

  localparam int unsigned H_TOTAL    = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
  localparam int unsigned V_TOTAL    = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;
  localparam int unsigned CHAR_SHIFT = $clog2(CHAR_W);

  localparam logic [10:0] HX_LAST  = 11'(H_TOTAL - 1);
  localparam logic [9:0]  VY_LAST  = 10'(V_TOTAL - 1);
  localparam logic [10:0] HX_ACT   = 11'(H_ACTIVE);
  localparam logic [9:0]  VY_ACT   = 10'(V_ACTIVE);
  localparam logic [10:0] HS_START = 11'(H_ACTIVE + H_FRONT);
  localparam logic [10:0] HS_END   = 11'(H_ACTIVE + H_FRONT + H_SYNC);
  localparam logic [9:0]  VS_START = 10'(V_ACTIVE + V_FRONT);
  localparam logic [9:0]  VS_END   = 10'(V_ACTIVE + V_FRONT + V_SYNC);
  localparam logic [10:0] CELL_MSK = 11'(CHAR_W - 1);
  localparam logic [9:0]  ROW_LAST = 10'(CHAR_H - 1);

  typedef enum logic [1:0] {StIdle, StWait, StAccess, StDone} arb_state_e;

  logic [10:0]       hx_q, hx_d;
  logic [9:0]        vy_q, vy_d;
  logic [9:0]        row_line_q, row_line_d;
  logic [ADDR_W-1:0] row_base_q, row_base_d;
  logic              h_wrap, v_wrap;
  logic              active_cur, fetch_cur;
  logic              active_nxt, fetch_nxt, allowed_nxt;
  logic              hs_win, vs_win;
  logic              hsync_q, vsync_q, pixel_ena_q, frame_start_q;
  arb_state_e        state_q, state_d;

  // Next-state counters; row_line tracks the line within a character row so
  // row_base can step by COLS without a multiplier.
  always_comb begin
    h_wrap     = (hx_q == HX_LAST);
    v_wrap     = h_wrap && (vy_q == VY_LAST);
    hx_d       = h_wrap ? 11'd0 : hx_q + 11'd1;
    vy_d       = vy_q;
    row_line_d = row_line_q;
    row_base_d = row_base_q;
    if (h_wrap) begin
      vy_d       = v_wrap ? 10'd0 : vy_q + 10'd1;
      row_line_d = (row_line_q == ROW_LAST) ? 10'd0 : row_line_q + 10'd1;
    end
    if (v_wrap) begin
      row_line_d = 10'd0;
      row_base_d = '0;
    end else if (h_wrap && (row_line_q == ROW_LAST) && (vy_d < VY_ACT)) begin
      row_base_d = row_base_q + ADDR_W'(COLS);
    end
  end

  // Active-area / fetch / access-permission decode on current and next counters.
  always_comb begin
    active_cur  = (hx_q < HX_ACT) && (vy_q < VY_ACT);
    fetch_cur   = active_cur && ((hx_q & CELL_MSK) == 11'd0);
    active_nxt  = (hx_d < HX_ACT) && (vy_d < VY_ACT);
    fetch_nxt   = active_nxt && ((hx_d & CELL_MSK) == 11'd0);
    allowed_nxt = (ACC_MODE == 0) ? !active_nxt : !fetch_nxt;
    hs_win      = (hx_q >= HS_START) && (hx_q < HS_END);
    vs_win      = (vy_q >= VS_START) && (vy_q < VS_END);
  end

  // Counters, row base and the registered video outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      hx_q          <= '0;
      vy_q          <= '0;
      row_line_q    <= '0;
      row_base_q    <= '0;
      hsync_q       <= ~HSYNC_POL;
      vsync_q       <= ~VSYNC_POL;
      pixel_ena_q   <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      hx_q          <= hx_d;
      vy_q          <= vy_d;
      row_line_q    <= row_line_d;
      row_base_q    <= row_base_d;
      hsync_q       <= hs_win ? HSYNC_POL : ~HSYNC_POL;
      vsync_q       <= vs_win ? VSYNC_POL : ~VSYNC_POL;
      pixel_ena_q   <= active_cur;
      // v_wrap means the next counters are exactly (0,0).
      frame_start_q <= v_wrap;
    end
  end

  // Arbiter state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Arbiter next state; permission is judged on the cycle ACCESS would occupy.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (cpu_req && allowed_nxt) begin
          state_d = StAccess;
        end else if (cpu_req) begin
          state_d = StWait;
        end
      end
      StWait: begin
        if (allowed_nxt) begin
          state_d = StAccess;
        end
      end
      StAccess: state_d = StDone;
      StDone:   state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  // Arbiter outputs, decoded from the state register.
  always_comb begin
    a_sel        = (state_q == StAccess);
    ram_we_text  = a_sel && cpu_we && !cpu_sel_color;
    ram_we_color = a_sel && cpu_we && cpu_sel_color;
    cpu_rdy      = (state_q == StDone);
  end

  // Port assignments for counters, fetch path and registered video outputs.
  always_comb begin
    hx          = hx_q;
    vy          = vy_q;
    hsync       = hsync_q;
    vsync       = vsync_q;
    pixel_ena   = pixel_ena_q;
    frame_start = frame_start_q;
    fetch_stb   = fetch_cur;
    fetch_addr  = row_base_q + ADDR_W'(hx_q >> CHAR_SHIFT);
  end

endmodule

// File: tb/tb_vga_timing_arb.sv
// Directed bench for vga_timing_arb: a default-geometry instance (ACC_MODE 0)
// and a small-geometry instance (ACC_MODE 1) share clock and reset.
module tb_vga_timing_arb;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Default-geometry instance.
  logic [10:0] d_hx;
  logic [9:0]  d_vy;
  logic        d_hsync, d_vsync, d_pena, d_fs, d_stb, d_asel, d_wet, d_wec, d_rdy;
  logic [11:0] d_addr;
  logic        d_req = 1'b0, d_we = 1'b0, d_selc = 1'b0;

  vga_timing_arb u_def (
    .clk(clk), .rst(rst), .hx(d_hx), .vy(d_vy), .hsync(d_hsync), .vsync(d_vsync),
    .pixel_ena(d_pena), .frame_start(d_fs), .fetch_stb(d_stb), .fetch_addr(d_addr),
    .a_sel(d_asel), .ram_we_text(d_wet), .ram_we_color(d_wec), .cpu_req(d_req),
    .cpu_we(d_we), .cpu_sel_color(d_selc), .cpu_rdy(d_rdy)
  );

  // Small geometry: H 32/4/8/4 (total 48), V 32/2/2/2 (total 38), 8x4 cells.
  logic [10:0] s_hx;
  logic [9:0]  s_vy;
  logic        s_hsync, s_vsync, s_pena, s_fs, s_stb, s_asel, s_wet, s_wec, s_rdy;
  logic [11:0] s_addr;
  logic        s_req = 1'b0, s_we = 1'b0, s_selc = 1'b0;

  vga_timing_arb #(
    .H_ACTIVE(32), .H_FRONT(4), .H_SYNC(8), .H_BACK(4),
    .V_ACTIVE(32), .V_FRONT(2), .V_SYNC(2), .V_BACK(2),
    .HSYNC_POL(1'b0), .VSYNC_POL(1'b0), .CHAR_W(8), .CHAR_H(4), .COLS(4),
    .ADDR_W(12), .ACC_MODE(1)
  ) u_sml (
    .clk(clk), .rst(rst), .hx(s_hx), .vy(s_vy), .hsync(s_hsync), .vsync(s_vsync),
    .pixel_ena(s_pena), .frame_start(s_fs), .fetch_stb(s_stb), .fetch_addr(s_addr),
    .a_sel(s_asel), .ram_we_text(s_wet), .ram_we_color(s_wec), .cpu_req(s_req),
    .cpu_we(s_we), .cpu_sel_color(s_selc), .cpu_rdy(s_rdy)
  );

  typedef struct {
    int hx;
    int vy;
    bit stb;
    int addr;
    bit pena;
    bit hs;
    bit vs;
  } vec_t;

  vec_t vecs[16];

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Step negedges until the chosen instance reaches (x,y); timeout is a failure.
  task automatic wait_pos(input bit sml, input int x, input int y);
    bit found = 1'b0;
    for (int n = 0; n < 50000 && !found; n++) begin
      @(negedge clk);
      if (sml) found = (int'(s_hx) == x) && (int'(s_vy) == y);
      else     found = (int'(d_hx) == x) && (int'(d_vy) == y);
    end
    if (!found) begin
      total++;
      bad++;
      $display("FAIL wait_pos(%0d,%0d,%0d): position not reached", sml, x, y);
    end
  endtask

  initial begin
    int lows, first_low, stb_err, fs_cnt, conflict, early, hits;
    int hs_cnt, vs_cnt, pe_cnt, st_cnt, hx_max, vy_max;
    bit got;

    // hx, vy, fetch_stb, fetch_addr, pixel_ena, hsync, vsync (small instance)
    vecs[0]  = '{1,  0,  1'b0, 0,  1'b1, 1'b1, 1'b1};
    vecs[1]  = '{8,  0,  1'b1, 1,  1'b1, 1'b1, 1'b1};
    vecs[2]  = '{32, 0,  1'b0, 4,  1'b1, 1'b1, 1'b1};
    vecs[3]  = '{33, 0,  1'b0, 4,  1'b0, 1'b1, 1'b1};
    vecs[4]  = '{36, 0,  1'b0, 4,  1'b0, 1'b1, 1'b1};
    vecs[5]  = '{37, 0,  1'b0, 4,  1'b0, 1'b0, 1'b1};
    vecs[6]  = '{44, 0,  1'b0, 5,  1'b0, 1'b0, 1'b1};
    vecs[7]  = '{45, 0,  1'b0, 5,  1'b0, 1'b1, 1'b1};
    vecs[8]  = '{0,  4,  1'b1, 4,  1'b0, 1'b1, 1'b1};
    vecs[9]  = '{24, 31, 1'b1, 31, 1'b1, 1'b1, 1'b1};
    vecs[10] = '{16, 33, 1'b0, 30, 1'b0, 1'b1, 1'b1};
    vecs[11] = '{0,  34, 1'b0, 28, 1'b0, 1'b1, 1'b1};
    vecs[12] = '{1,  34, 1'b0, 28, 1'b0, 1'b1, 1'b0};
    vecs[13] = '{0,  36, 1'b0, 28, 1'b0, 1'b1, 1'b0};
    vecs[14] = '{1,  36, 1'b0, 28, 1'b0, 1'b1, 1'b1};
    vecs[15] = '{8,  37, 1'b0, 29, 1'b0, 1'b1, 1'b1};

    // Reset values.
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_hx", int'(d_hx), 0);
    check("rst_vy", int'(d_vy), 0);
    check("rst_hsync", int'(d_hsync), 1);
    check("rst_vsync", int'(d_vsync), 1);
    check("rst_pixel_ena", int'(d_pena), 0);
    check("rst_frame_start", int'(d_fs), 0);
    check("rst_outs", int'({d_asel, d_wet, d_wec, d_rdy}), 0);
    check("rst_fetch_addr", int'(d_addr), 0);
    rst = 1'b0;

    // First line with defaults: hsync width/start, fetch_stb decode.
    lows = 0; first_low = -1; stb_err = 0; fs_cnt = 0;
    for (int k = 1; k <= 800; k++) begin
      @(negedge clk);
      if (!d_hsync) begin
        lows++;
        if (first_low < 0) first_low = int'(d_hx);
      end
      if (d_stb != ((d_hx < 640) && (d_vy < 480) && (d_hx % 8 == 0))) stb_err++;
      if (d_fs) fs_cnt++;
    end
    check("def_hsync_low_cycles", lows, 96);
    check("def_hsync_first_low_hx", first_low, 657);
    check("def_fetch_stb_decode_errs", stb_err, 0);
    check("def_no_frame_start", fs_cnt, 0);
    check("def_line_wrap_vy", int'(d_vy), 1);

    // ACC_MODE 0: text write requested mid-line waits for horizontal blanking.
    wait_pos(1'b0, 100, 10);
    d_req = 1'b1; d_we = 1'b1; d_selc = 1'b0;
    conflict = 0; early = 0; got = 1'b0;
    for (int n = 0; n < 2000 && !got; n++) begin
      @(negedge clk);
      if (d_asel && d_stb) conflict++;
      if (d_rdy) early++;
      got = d_asel;
    end
    check("acc0_access_seen", int'(got), 1);
    check("acc0_access_hx", int'(d_hx), 640);
    check("acc0_we_text", int'(d_wet), 1);
    check("acc0_we_color", int'(d_wec), 0);
    check("acc0_no_early_rdy", early, 0);
    check("acc0_no_fetch_conflict", conflict, 0);
    @(negedge clk);
    check("acc0_rdy", int'(d_rdy), 1);
    check("acc0_done_strobes", int'({d_asel, d_wet, d_wec}), 0);
    d_req = 1'b0;
    @(negedge clk);
    check("acc0_rdy_one_cycle", int'(d_rdy), 0);

    // Row stepping of fetch_addr.
    wait_pos(1'b0, 0, 16);
    check("def_addr_0_16", int'(d_addr), 80);
    check("def_stb_0_16", int'(d_stb), 1);
    wait_pos(1'b0, 8, 16);
    check("def_addr_8_16", int'(d_addr), 81);
    wait_pos(1'b0, 639, 16);
    check("def_addr_639_16", int'(d_addr), 159);
    check("def_stb_639_16", int'(d_stb), 0);

    // Reset while waiting aborts the transfer.
    wait_pos(1'b0, 200, 20);
    d_req = 1'b1; d_we = 1'b1; d_selc = 1'b0;
    @(negedge clk);
    check("wait_no_access", int'({d_asel, d_rdy}), 0);
    rst = 1'b1;
    @(negedge clk);
    check("abort_hx", int'(d_hx), 0);
    check("abort_vy", int'(d_vy), 0);
    check("abort_outs", int'({d_asel, d_wet, d_wec, d_rdy}), 0);
    rst = 1'b0; d_req = 1'b0;
    hits = 0;
    for (int n = 0; n < 700; n++) begin
      @(negedge clk);
      if (d_asel || d_rdy) hits++;
    end
    check("abort_stays_idle", hits, 0);

    // Small instance: two full frames.
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    fs_cnt = 0; hs_cnt = 0; vs_cnt = 0; pe_cnt = 0; st_cnt = 0; hx_max = 0; vy_max = 0;
    hits = 0;
    for (int k = 1; k <= 2 * 1824; k++) begin
      @(negedge clk);
      if (s_fs) fs_cnt++;
      if (!s_hsync) hs_cnt++;
      if (!s_vsync) vs_cnt++;
      if (s_pena) pe_cnt++;
      if (s_stb) st_cnt++;
      if (s_asel) hits++;
      if (int'(s_hx) > hx_max) hx_max = int'(s_hx);
      if (int'(s_vy) > vy_max) vy_max = int'(s_vy);
    end
    check("sml_frame_starts", fs_cnt, 2);
    check("sml_fs_at_origin", int'({s_fs, s_hx, s_vy}), 1 << 21);
    check("sml_hsync_lows", hs_cnt, 608);
    check("sml_vsync_lows", vs_cnt, 192);
    check("sml_pixel_ena_highs", pe_cnt, 2048);
    check("sml_fetch_stbs", st_cnt, 256);
    check("sml_hx_max", hx_max, 47);
    check("sml_vy_max", vy_max, 37);
    check("sml_no_idle_access", hits, 0);

    // Table-driven positions through frame 3.
    for (int i = 0; i < 16; i++) begin
      wait_pos(1'b1, vecs[i].hx, vecs[i].vy);
      check($sformatf("vec%0d_stb", i), int'(s_stb), int'(vecs[i].stb));
      check($sformatf("vec%0d_addr", i), int'(s_addr), vecs[i].addr);
      check($sformatf("vec%0d_pena", i), int'(s_pena), int'(vecs[i].pena));
      check($sformatf("vec%0d_hsync", i), int'(s_hsync), int'(vecs[i].hs));
      check($sformatf("vec%0d_vsync", i), int'(s_vsync), int'(vecs[i].vs));
    end

    // ACC_MODE 1: request whose ACCESS would hit a fetch slips one cycle.
    wait_pos(1'b1, 15, 1);
    s_req = 1'b1; s_we = 1'b0; s_selc = 1'b1;
    got = 1'b0; conflict = 0; hits = 0;
    for (int n = 0; n < 100 && !got; n++) begin
      @(negedge clk);
      if (s_asel && s_stb) conflict++;
      if (s_wet || s_wec) hits++;
      got = s_asel;
    end
    check("acc1_access_seen", int'(got), 1);
    check("acc1_access_hx", int'(s_hx), 17);
    check("acc1_read_no_strobe", hits, 0);
    check("acc1_no_fetch_conflict", conflict, 0);
    @(negedge clk);
    check("acc1_rdy", int'(s_rdy), 1);
    check("acc1_rdy_hx", int'(s_hx), 18);
    s_req = 1'b0;

    // ACC_MODE 1: colour write on a non-fetch cycle gets minimum latency.
    wait_pos(1'b1, 2, 2);
    s_req = 1'b1; s_we = 1'b1; s_selc = 1'b1;
    @(negedge clk);
    check("acc1w_a_sel", int'(s_asel), 1);
    check("acc1w_hx", int'(s_hx), 3);
    check("acc1w_strobes", int'({s_wet, s_wec}), 1);
    @(negedge clk);
    check("acc1w_rdy", int'(s_rdy), 1);
    s_req = 1'b0;
    @(negedge clk);
    check("acc1w_idle", int'({s_asel, s_rdy}), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/vga_timing_arb.md
# vga_timing_arb

Parametrised VGA timing generator and video-RAM access arbiter. It replaces external h/v counters and fixed 640×480 decode with internal counters whose geometry, sync polarity and character cell size are parameters. It also adds a character-fetch address generator and a CPU request/ready handshake with two arbitration modes: blanking-only, and cycle-stealing during the active area. It sits between the CPU bus, the text/colour RAMs and the pixel shifter.

## Interface
- H_ACTIVE, 640, visible pixels per line
- H_FRONT / H_SYNC / H_BACK, 16 / 96 / 48, horizontal porch and sync widths in pixels
- V_ACTIVE, 480, visible lines
- V_FRONT / V_SYNC / V_BACK, 10 / 2 / 33, vertical porch and sync widths in lines
- HSYNC_POL / VSYNC_POL, 0 / 0, active level of the sync outputs
- CHAR_W, 8, character width in pixels, power of two
- CHAR_H, 16, character height in lines
- COLS, 80, characters per row; COLS*CHAR_W == H_ACTIVE
- ADDR_W, 12, RAM address width
- ACC_MODE, 0, 0 = CPU access in blanking only, 1 = also in active-area non-fetch cycles
- clk  in  1  pixel clock; every counter and register updates on the rising edge
- rst  in  1  synchronous, active-high reset
- hx  out  11  column counter (0..H_TOTAL-1)
- vy  out  10  line counter (0..V_TOTAL-1)
- hsync / vsync  out  1  registered sync outputs
- pixel_ena  out  1  registered; 1 = the shifter outputs pixels
- frame_start  out  1  one-cycle pulse when the counters wrap to (0,0)
- fetch_stb  out  1  1 in display fetch cycles
- fetch_addr  out  ADDR_W  character index of the cell being fetched
- a_sel  out  1  RAM address mux select: 0 = fetch_addr, 1 = cpu_addr
- ram_we_text / ram_we_color  out  1  active-high RAM write strobes
- cpu_req  in  1  CPU access request, held until cpu_rdy
- cpu_we  in  1  1 = write, 0 = read; stable while cpu_req is high
- cpu_sel_color  in  1  0 = text RAM, 1 = colour RAM
- cpu_rdy  out  1  one-cycle completion pulse

## Operation
- H_TOTAL is the sum of the four H parameters; V_TOTAL is the sum of the four V parameters.
- hx increments every cycle and wraps from H_TOTAL-1 to 0. vy increments when hx wraps and wraps from V_TOTAL-1 to 0.
- active = (hx < H_ACTIVE) && (vy < V_ACTIVE).
- Fetch cycle = active && (hx mod CHAR_W == 0). fetch_stb is combinational from the counters.
- fetch_addr = row_base + hx/CHAR_W. row_base is a register with no multiplier:
  - It clears at vy wrap.
  - It adds COLS when hx wraps and the new vy is a multiple of CHAR_H with vy < V_ACTIVE.
  - Arithmetic is modulo 2^ADDR_W.
- allowed(c) for cycle c:
  - ACC_MODE 0: !active.
  - ACC_MODE 1: !active || !fetch cycle.
  - allowed is always evaluated on the counter values the ACCESS cycle will have, i.e. the next-state counters.
- Arbiter FSM:
  - IDLE: if cpu_req && allowed(next) go to ACCESS; else if cpu_req go to WAIT.
  - WAIT: go to ACCESS when allowed(next).
  - ACCESS (exactly 1 cycle):
    - a_sel = 1.
    - ram_we_text = cpu_we && !cpu_sel_color; ram_we_color = cpu_we && cpu_sel_color.
    - Read data is valid on the RAM bus at the end of this cycle.
    - Next state is DONE.
  - DONE: cpu_rdy = 1, next state IDLE. A cpu_req still high in the following IDLE cycle counts as a new request.
- a_sel = 0 and both write strobes = 0 outside ACCESS. A fetch and a CPU access never share a cycle.

## Timing
- Reset values:
  - hx = 0, vy = 0, row_base = 0.
  - hsync = !HSYNC_POL, vsync = !VSYNC_POL (inactive levels).
  - pixel_ena = 0, frame_start = 0, cpu_rdy = 0, a_sel = 0, write strobes = 0.
  - FSM = IDLE.
- hsync, vsync and pixel_ena are registered from the current counters, so they lag hx/vy by 1 cycle. This matches the synchronous-RAM fetch latency.
- hsync is active in the cycle after hx is in [H_ACTIVE+H_FRONT, H_ACTIVE+H_FRONT+H_SYNC-1]. vsync uses the same rule on vy with the V parameters.
- frame_start is registered: it is high in the cycle where hx = 0 and vy = 0.
- CPU latency:
  - Minimum is 2 cycles from the first edge sampling cpu_req to the cpu_rdy pulse (ACCESS, then DONE).
  - Worst case in ACC_MODE 0 is one full active line plus 2 cycles. During vertical blanking every cycle is allowed.
- Reset asserted during WAIT or ACCESS aborts the transfer: no cpu_rdy, strobes low on the next cycle. The CPU must re-request.
- cpu_req dropping during WAIT is a protocol error; behaviour is undefined and is not checked.

## Test plan
- Assert rst for 3 cycles -> all outputs at the reset values above; first post-reset cycle has hx = 0, vy = 0; hsync = 1, vsync = 1 with default parameters.
- Run 2 frames with defaults -> hsync low for exactly 96 cycles, starting the cycle after hx = 656; vsync low for lines 490–491; hx wraps at 799, vy wraps at 524; frame_start pulses once per 420000 cycles.
- Check fetch_addr -> 0 at (0,0); 80 at (0,16); 2399 at (632,479); fetch_stb only when hx mod 8 = 0 in the active area.
- ACC_MODE 0: cpu_req write to text RAM raised at hx = 100, vy = 10 -> ACCESS at hx = 640, ram_we_text for 1 cycle, cpu_rdy the next cycle, a_sel never 1 while fetch_stb = 1.
- ACC_MODE 1: request raised when the next hx = 16 (a fetch cycle) -> ACCESS at hx = 17, cpu_rdy at hx = 18; a read with cpu_sel_color = 1 produces no write strobe.
- rst pulsed while the FSM is in WAIT -> no cpu_rdy, FSM IDLE, counters at 0 on the next cycle.
